aes_round_engine: RTL

- Iterative AES-128 encryption datapath that consumes the 1408-bit round-key bus produced by `keyexpansion`.
- Executes one full round per clock: SubBytes via the existing `subBytes`/`sbox`, ShiftRows via the existing `ShiftRows`, then MixColumns and AddRoundKey.
- Sits between the plaintext source (UART/switch loader) and the display/`decoder` path.
- Uses a valid/ready handshake on both input and output.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/ShiftRows.sv | 14 +
 rtl/mix_columns.sv | 23 ++
 rtl/sbox.sv | 11 +
 rtl/subBytes.sv | 14 +
 rtl/aes_round_engine.sv | 105 ++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8)/S-box/round-key helpers.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned KEY_BUS_W  = (NUM_ROUNDS + 1) * 128;
    localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } aes_state_e;

    // Forward S-box, entry v at [2047-8v -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round key r sits at [KEY_BUS_W-1-128r -: 128]; out-of-range indices yield zero.
    function automatic logic [127:0] round_key(input logic [KEY_BUS_W-1:0] keys,
                                               input logic [3:0]           r);
        if (r > LAST_ROUND) begin
            return '0;
        end
        return keys[KEY_BUS_W - 1 - 128 * int'(r) -: 128];
    endfunction

endpackage

// File: rtl/ShiftRows.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
module ShiftRows (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign state_o[127 - 8 * (r + 4 * c) -: 8] =
                state_i[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
        end
    end

endmodule

// File: rtl/mix_columns.sv
// MixColumns over four independent state columns in GF(2^8).
module mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;

        assign a0 = state_i[127 - 32 * c -: 8];
        assign a1 = state_i[119 - 32 * c -: 8];
        assign a2 = state_i[111 - 32 * c -: 8];
        assign a3 = state_i[103 - 32 * c -: 8];

        assign state_o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign state_o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign state_o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign state_o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/sbox.sv
// Single-byte AES forward S-box lookup.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    assign data_o = sbox_byte(data_i);

endmodule

// File: rtl/subBytes.sv
// SubBytes: sixteen parallel S-box lookups over the 128-bit state.
module subBytes (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    for (genvar k = 0; k < 16; k++) begin : g_byte
        sbox u_sbox (
            .data_i (state_i[127 - 8 * k -: 8]),
            .data_o (state_o[127 - 8 * k -: 8])
        );
    end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor: one full round per clock, valid/ready on both sides.
// The round-key bus is not latched; the source holds it from acceptance to out_valid.
module aes_round_engine
    import aes_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [127:0]         plaintext_i,
    input  logic [KEY_BUS_W-1:0] keys_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [127:0]         ciphertext_o,
    output logic                 busy_o
);

    aes_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_cnt_q, round_cnt_d;

    logic [127:0] sb_out, sr_out, mc_out, rk, round_out;

    subBytes u_sub_bytes (
        .state_i (state_q),
        .state_o (sb_out)
    );

    ShiftRows u_shift_rows (
        .state_i (sb_out),
        .state_o (sr_out)
    );

    mix_columns u_mix_columns (
        .state_i (sr_out),
        .state_o (mc_out)
    );

    // 11:1 round-key mux; the final round skips MixColumns.
    assign rk        = round_key(keys_i, round_cnt_q);
    assign round_out = ((round_cnt_q == LAST_ROUND) ? sr_out : mc_out) ^ rk;

    assign ciphertext_o = state_q;

    // State, round counter and FSM registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            round_cnt_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_d     = plaintext_i ^ round_key(keys_i, 4'd0);
                    round_cnt_d = 4'd1;
                    fsm_d       = StRound;
                end
            end
            StRound: begin
                busy_o = 1'b1;
                // Counter values outside 1..NUM_ROUNDS are unreachable; recover to idle.
                if (round_cnt_q == 4'd0 || round_cnt_q > LAST_ROUND) begin
                    round_cnt_d = '0;
                    fsm_d       = StIdle;
                end else begin
                    state_d = round_out;
                    if (round_cnt_q == LAST_ROUND) begin
                        round_cnt_d = '0;
                        fsm_d       = StDone;
                    end else begin
                        round_cnt_d = round_cnt_q + 4'd1;
                    end
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    fsm_d = StIdle;
                end
            end
            default: begin
                fsm_d       = StIdle;
                round_cnt_d = '0;
            end
        endcase
    end

endmodule
